uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (tx_start/tx_data/tx_ready handshake) among NREQ byte sources.
//  Sources: initial-message ROM, scan-out streamer, PO reporter, debug echo.
//  Round-robin arbitration per byte; a source may lock the grant to send a contiguous multi-byte message.
//  Sits between the command-parser sub-blocks and the UART TX.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  TIMEOUT  1024  cycles allowed for tx_ready_i to drop after tx_start_o (used only with TX_ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1        system clock
//  rstn        in   1        asynchronous reset, active-low
//  req_i       in   NREQ     byte request per source; held with data until ack_o
//  lock_i      in   NREQ     keep grant after current byte (multi-byte message)
//  data_i      in   NREQ*8   byte per source; source k at [8k+7:8k]
//  ack_o       out  NREQ     1-cycle pulse: source k's byte fully transmitted
//  gnt_o       out  NREQ     one-hot current owner of the transmitter
//  busy_o      out  1        state != IDLE
//  err_o       out  1        sticky timeout flag (0 without TX_ARB_TIMEOUT_EN)
//  tx_start_o  out  1        start strobe to UART TX
//  tx_data_o   out  8        byte to UART TX
//  tx_ready_i  in   1        UART TX idle
// BEHAVIOUR
//  Reset (async): all outputs 0; state IDLE; rr pointer 0 (source 0 highest priority); err_o 0.
//  Reset mid-transfer: outputs drop immediately; no ack issued; transfer is abandoned.
//  Arbitration: search req_i starting at pointer, wrapping modulo NREQ; first set bit wins.
//  Pointer <= winner+1 (mod NREQ), updated only on ack, never in HOLD.
//  FSM:
//   IDLE: if |req_i && tx_ready_i -> latch gnt_o=winner, tx_data_o=data_i[winner] -> START.
//         No grant while tx_ready_i=0.
//   START: tx_start_o=1 (first cycle = 1 cycle after req sampled).
//         When tx_ready_i=0: tx_start_o<=0 -> WAIT_DONE.
//   WAIT_DONE: when tx_ready_i=1: ack_o[gnt]=1 for one cycle, update pointer.
//         If lock_i[gnt]=1 -> HOLD; else gnt_o<=0 -> IDLE.
//   HOLD: gnt_o kept. If req_i[gnt] && tx_ready_i -> latch data_i[gnt] -> START.
//         Else if !lock_i[gnt] -> gnt_o<=0 -> IDLE. Other requests ignored while in HOLD.
//  tx_data_o latched once per byte; it does not follow data_i changes during a transfer.
//  req_i dropped mid-transfer: transfer completes, ack still pulsed (protocol violation, tolerated).
//  A source may re-raise req_i the cycle after its ack. It competes in IDLE with pointer already advanced.
//  Simultaneous lock drop and new req in HOLD: req wins (byte sent), lock checked again at its ack.
//  Non-granted ack_o/gnt_o bits are always 0; gnt_o is one-hot or zero.
// CONFIGURATION
//  TX_ARB_TIMEOUT_EN defined:
//   Counter runs in START. If tx_ready_i is still 1 after TIMEOUT cycles:
//   tx_start_o<=0, err_o<=1 (sticky until rstn), no ack, gnt_o<=0 -> IDLE.
//   Pointer is unchanged, so the same source retries.
//  Not defined: START waits indefinitely; err_o tied 0; TIMEOUT ignored.
// TESTING
//  (TX model: ready drops 1 cycle after start, stays low 10 cycles.)
//  1. req_i=0010, data 0x41, ready=1 -> tx_start_o=1 next cycle, tx_data_o=0x41, gnt_o=0010.
//     ack_o=0010 one cycle on ready rise; then IDLE, gnt_o=0.
//  2. req_i=0101 held, re-raised after each ack, from reset -> grant order 0,2,0,2; exactly one ack per byte.
//  3. Source 1 lock_i=1 for bytes 0x61,0x62,0x63 while req_i[0]=1 -> three bytes from 1 contiguous;
//     source 0 granted only after lock drops.
//  4. tx_ready_i=0 with req_i=1000 for 20 cycles -> tx_start_o stays 0, busy_o=0;
//     ready rises -> tx_start_o next cycle.
//  5. rstn pulsed low during WAIT_DONE -> all outputs 0 same cycle, no ack.
//     After release, req_i=1001 -> source 0 wins.
//  6. TX_ARB_TIMEOUT_EN, TIMEOUT=16, ready stuck at 1 -> tx_start_o drops after 16 cycles, err_o=1, no ack,
//     same source retried.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter (tx_start/tx_data/tx_ready handshake) among
//   NREQ byte sources. Bytes are granted round-robin one at a time. A source
//   that holds lock_i keeps the grant after its byte, so it can send a
//   multi-byte message without interleaving.
//
//   Build option: define TX_ARB_TIMEOUT_EN to enable the start timeout.
//   When it is enabled and the UART never drops tx_ready_i within TIMEOUT
//   cycles of a start, the byte is abandoned and err_o is set (sticky). The
//   pointer is not advanced, so the same source is tried again.
//
// Ports
//   clk, rstn     system clock, asynchronous active-low reset
//   req_i[NREQ]   byte request per source, held with data until ack_o
//   lock_i[NREQ]  keep the grant after the current byte
//   data_i        byte per source, source k at [8k+7:8k]
//   ack_o[NREQ]   one-cycle pulse when the granted source's byte is done
//   gnt_o[NREQ]   one-hot current owner, or zero
//   busy_o        arbiter is not idle
//   err_o         sticky start-timeout flag (always 0 without the option)
//   tx_start_o    start strobe to the UART
//   tx_data_o     byte to the UART, latched once per byte
//   tx_ready_i    UART is idle
//
// States
//   IDLE      | no owner, waiting for a request while the UART is ready
//   START     | tx_start_o high, waiting for the UART to drop tx_ready_i
//   WAIT_DONE | UART is sending, waiting for tx_ready_i to return
//   HOLD      | locked owner keeps the grant between bytes
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   lock_i,
  input  logic [NREQ*8-1:0] data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t          r_state, w_state_n;
  logic [NREQ-1:0] r_gnt, w_gnt_n;
  logic [NREQ-1:0] r_ack, w_ack_n;
  logic [PW-1:0]   r_idx, w_idx_n;
  logic [PW-1:0]   r_ptr, w_ptr_n;
  logic [7:0]      r_data, w_data_n;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_k;

  function automatic logic [PW-1:0] f_next_idx(input logic [PW-1:0] idx);
    int n;
    n = int'(idx) + 1;
    if (n >= NREQ) n = 0;
    return PW'(n);
  endfunction

  // Rotating search: first requester at or after the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_k     = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_i[w_k]) begin
        w_found = 1'b1;
        w_win   = w_k;
      end
      w_k = f_next_idx(w_k);
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_err, w_err_n;
`endif

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_idx_n   = r_idx;
    w_ptr_n   = r_ptr;
    w_data_n  = r_data;
    w_ack_n   = '0;
`ifdef TX_ARB_TIMEOUT_EN
    w_cnt_n   = r_cnt;
    w_err_n   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found && tx_ready_i) begin
          w_state_n = S_START;
          w_gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_idx_n   = w_win;
          w_data_n  = data_i[{w_win, 3'b000} +: 8];
`ifdef TX_ARB_TIMEOUT_EN
          w_cnt_n   = CW'(TIMEOUT - 1);
`endif
        end
      end
      S_START: begin
        if (!tx_ready_i) begin
          w_state_n = S_WAIT_DONE;
        end
`ifdef TX_ARB_TIMEOUT_EN
        // UART never accepted the start: drop the byte, pointer untouched.
        else if (r_cnt == '0) begin
          w_state_n = S_IDLE;
          w_gnt_n   = '0;
          w_err_n   = 1'b1;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (tx_ready_i) begin
          w_ack_n = r_gnt;
          w_ptr_n = f_next_idx(r_idx);
          if (lock_i[r_idx]) begin
            w_state_n = S_HOLD;
          end else begin
            w_state_n = S_IDLE;
            w_gnt_n   = '0;
          end
        end
      end
      S_HOLD: begin
        // A new byte from the owner beats a simultaneous lock release; the
        // lock is looked at again when that byte is acknowledged.
        if (req_i[r_idx] && tx_ready_i) begin
          w_state_n = S_START;
          w_data_n  = data_i[{r_idx, 3'b000} +: 8];
`ifdef TX_ARB_TIMEOUT_EN
          w_cnt_n   = CW'(TIMEOUT - 1);
`endif
        end else if (!lock_i[r_idx]) begin
          w_state_n = S_IDLE;
          w_gnt_n   = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_ack   <= w_ack_n;
      r_idx   <= w_idx_n;
      r_ptr   <= w_ptr_n;
      r_data  <= w_data_n;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_n;
      r_err <= w_err_n;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign ack_o      = r_ack;
  assign gnt_o      = r_gnt;
  assign busy_o     = (r_state != S_IDLE);
  assign tx_start_o = (r_state == S_START);
  assign tx_data_o  = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Sources are driven from per-source byte
// queues; every expected (source, byte) is pushed to a scoreboard when the
// stimulus is issued and popped by a monitor on each ack_o pulse.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_i = '0;
  logic [NREQ-1:0]   lock_i = '0;
  logic [NREQ*8-1:0] data_i = '0;
  logic [NREQ-1:0]   ack_o;
  logic [NREQ-1:0]   gnt_o;
  logic              busy_o;
  logic              err_o;
  logic              tx_start_o;
  logic [7:0]        tx_data_o;
  logic              tx_ready_i;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .gnt_o      (gnt_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic lock; } src_t;
  typedef struct packed { logic [1:0] src; logic [7:0] data; } exp_t;

  src_t srcq[NREQ][$];
  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // UART model: ready drops one cycle after a start and stays low 10 cycles.
  // tx_mode 1 forces ready low, tx_mode 2 forces it high.
  int         tx_mode = 0;
  logic [3:0] tx_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) tx_cnt <= 4'd0;
    else if (tx_cnt != 4'd0) tx_cnt <= tx_cnt - 4'd1;
    else if (tx_start_o && tx_ready_i) tx_cnt <= 4'd10;
  end

  assign tx_ready_i = (tx_mode == 1) ? 1'b0 : (tx_mode == 2) ? 1'b1 : (tx_cnt == 4'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < NREQ; k++) begin
      if (srcq[k].size() > 0) begin
        req_i[k]          = 1'b1;
        lock_i[k]         = srcq[k][0].lock;
        data_i[8*k +: 8]  = srcq[k][0].data;
      end else begin
        req_i[k]  = 1'b0;
        lock_i[k] = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NREQ; k++) srcq[k].delete();
    expq.delete();
    req_i  = '0;
    lock_i = '0;
    data_i = '0;
  endtask

  task automatic push_src(input int k, input logic [7:0] d, input logic l);
    src_t s;
    s.data = d;
    s.lock = l;
    srcq[k].push_back(s);
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    exp_t e;
    e.src  = 2'(k);
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0;
    clear_all();
    tx_mode = 0;
    repeat (2) step();
    rstn = 1'b1;
  endtask

  function automatic bit pending();
    bit p;
    p = (expq.size() != 0) || busy_o;
    for (int k = 0; k < NREQ; k++) if (srcq[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!pending()) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check({name, "_completed"}, 32'(done), 32'd1);
    check({name, "_scoreboard_empty"}, 32'(expq.size()), 32'd0);
  endtask

  // Source driver: retire a byte on its ack, present the next one at once.
  always begin
    @(posedge clk);
    #1;
    if (rstn) begin
      for (int k = 0; k < NREQ; k++)
        if (ack_o[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      drive_src();
    end
  end

  // Monitor: capture owner/byte at each start, compare on each ack pulse.
  logic       prev_start = 1'b0;
  logic [3:0] cap_gnt = '0;
  logic [7:0] cap_data = '0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (tx_start_o && !prev_start) begin
      cap_gnt  = gnt_o;
      cap_data = tx_data_o;
    end
    prev_start = tx_start_o;
    if (ack_o != '0) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack 0x%0h, expected no ack", ack_o);
      end else begin
        mon_e = expq.pop_front();
        check("ack_source", 32'(ack_o), 32'(1) << mon_e.src);
        check("start_owner", 32'(cap_gnt), 32'(1) << mon_e.src);
        check("start_byte", 32'(cap_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    bit flag;
    int run;

    // Reset state
    repeat (2) step();
    check("reset_outputs", 32'({ack_o, gnt_o, busy_o, err_o, tx_start_o, tx_data_o}), 32'd0);
    rstn = 1'b1;
    step();

    // 1: single byte from source 1
    push_src(1, 8'h41, 1'b0);
    push_exp(1, 8'h41);
    drive_src();
    step();
    check("t1_start", 32'(tx_start_o), 32'd1);
    check("t1_data", 32'(tx_data_o), 32'h41);
    check("t1_gnt", 32'(gnt_o), 32'h2);
    check("t1_busy", 32'(busy_o), 32'd1);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack_o != '0) begin
        flag = 1'b1;
        break;
      end
    end
    check("t1_ack_seen", 32'(flag), 32'd1);
    check("t1_ack_value", 32'(ack_o), 32'h2);
    step();
    check("t1_ack_one_cycle", 32'(ack_o), 32'h0);
    check("t1_gnt_released", 32'(gnt_o), 32'h0);
    check("t1_idle", 32'(busy_o), 32'd0);
    wait_done("t1", 40);

    // 2: sources 0 and 2 re-raising after each ack -> 0,2,0,2
    do_reset();
    push_src(0, 8'h10, 1'b0);
    push_src(0, 8'h11, 1'b0);
    push_src(2, 8'h20, 1'b0);
    push_src(2, 8'h21, 1'b0);
    push_exp(0, 8'h10);
    push_exp(2, 8'h20);
    push_exp(0, 8'h11);
    push_exp(2, 8'h21);
    drive_src();
    wait_done("t2", 200);

    // 3: locked three-byte message from source 1, source 0 waits
    do_reset();
    push_src(1, 8'h61, 1'b1);
    push_src(1, 8'h62, 1'b1);
    push_src(1, 8'h63, 1'b0);
    push_exp(1, 8'h61);
    push_exp(1, 8'h62);
    push_exp(1, 8'h63);
    push_exp(0, 8'h0A);
    drive_src();
    repeat (3) step();
    push_src(0, 8'h0A, 1'b0);
    drive_src();
    wait_done("t3", 200);

    // 4: no grant while the UART is not ready
    do_reset();
    tx_mode = 1;
    push_src(3, 8'h5A, 1'b0);
    push_exp(3, 8'h5A);
    drive_src();
    flag = 1'b0;
    repeat (20) begin
      step();
      if (tx_start_o || busy_o) flag = 1'b1;
    end
    check("t4_held_off", 32'(flag), 32'd0);
    tx_mode = 0;
    step();
    check("t4_start_after_ready", 32'(tx_start_o), 32'd1);
    check("t4_gnt", 32'(gnt_o), 32'h8);
    check("t4_data", 32'(tx_data_o), 32'h5A);
    wait_done("t4", 40);

    // 5: reset during WAIT_DONE abandons the byte
    do_reset();
    push_src(2, 8'h77, 1'b0);
    drive_src();
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy_o && !tx_start_o) begin
        flag = 1'b1;
        break;
      end
    end
    check("t5_reached_wait", 32'(flag), 32'd1);
    repeat (3) step();
    rstn = 1'b0;
    clear_all();
    #1;
    check("t5_outputs_cleared", 32'({ack_o, gnt_o, busy_o, err_o, tx_start_o, tx_data_o}), 32'd0);
    repeat (2) step();
    rstn = 1'b1;
    push_src(0, 8'h90, 1'b0);
    push_src(3, 8'h93, 1'b0);
    push_exp(0, 8'h90);
    push_exp(3, 8'h93);
    drive_src();
    step();
    check("t5_src0_wins", 32'(gnt_o), 32'h1);
    wait_done("t5", 80);

    // 6: UART never drops ready
    do_reset();
    tx_mode = 2;
    push_src(1, 8'h33, 1'b0);
    push_src(3, 8'h3B, 1'b0);
    drive_src();
    step();
    check("t6_start", 32'(tx_start_o), 32'd1);
    check("t6_gnt", 32'(gnt_o), 32'h2);
`ifdef TX_ARB_TIMEOUT_EN
    run = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!tx_start_o) break;
      run++;
    end
    check("t6_start_cycles", 32'(run), 32'(TIMEOUT));
    check("t6_err_set", 32'(err_o), 32'd1);
    check("t6_gnt_dropped", 32'(gnt_o), 32'h0);
    check("t6_idle", 32'(busy_o), 32'd0);
    step();
    check("t6_retry_start", 32'(tx_start_o), 32'd1);
    check("t6_retry_same_src", 32'(gnt_o), 32'h2);
    check("t6_err_sticky", 32'(err_o), 32'd1);
`else
    run = 0;
    flag = 1'b0;
    repeat (40) begin
      step();
      if (!tx_start_o || err_o) flag = 1'b1;
    end
    check("t6_start_held", 32'(flag), 32'd0);
    check("t6_gnt_held", 32'(gnt_o), 32'h2);
`endif
    do_reset();
    check("t6_err_cleared", 32'(err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
